// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier slice.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } booth_state_t;

  localparam int WIDTH_M_DEF = 16;

  // Booth recoding of the pair {Q[0], q_1}
  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  function automatic logic [1:0] boothOp(input logic qLsb, input logic qPrev);
    logic [1:0] op;
    case ({qLsb, qPrev})
      2'b01:   op = BOOTH_ADD;
      2'b10:   op = BOOTH_SUB;
      default: op = BOOTH_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: conditional add/sub of M into A,
// then an arithmetic right shift of the {A, Q, q_1} triple.
import booth_pkg::*;

module booth_step #(
  parameter int WIDTH_M = WIDTH_M_DEF
) (
  input  logic [WIDTH_M:0]   i_a,
  input  logic [WIDTH_M-1:0] i_q,
  input  logic               i_q1,
  input  logic [WIDTH_M:0]   i_m,
  output logic [WIDTH_M:0]   o_a,
  output logic [WIDTH_M-1:0] o_q,
  output logic               o_q1
);

  logic [1:0]       w_op;
  logic [WIDTH_M:0] w_sum;

  // Select the partial-product update; A is one bit wider than the operands so
  // adding or subtracting the most negative multiplicand never overflows.
  always_comb begin
    w_op  = boothOp(i_q[0], i_q1);
    w_sum = i_a;
    case (w_op)
      BOOTH_ADD: w_sum = i_a + i_m;
      BOOTH_SUB: w_sum = i_a - i_m;
      default:   w_sum = i_a;
    endcase
  end

  // Arithmetic shift right of {A', Q, q_1}, replicating the sign of A'
  always_comb begin
    o_a  = {w_sum[WIDTH_M], w_sum[WIDTH_M:1]};
    o_q  = {w_sum[0], i_q[WIDTH_M-1:1]};
    o_q1 = i_q[0];
  end

endmodule

// File: rtl/booth_mult_core.sv
// Sequential radix-2 Booth multiplier: accepts operands on start/ready, runs
// one Booth step per clock and presents the product with a one-cycle en_fp.
import booth_pkg::*;

module booth_mult_core #(
  parameter int WIDTH_M  = WIDTH_M_DEF,
  parameter int WIDTH_FP = 2 * WIDTH_M
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH_M-1:0]  multiplicand,
  input  logic [WIDTH_M-1:0]  multiplier,
  output logic                ready,
  output logic [WIDTH_FP-1:0] product,
  output logic                en_fp
);

  localparam int CW = $clog2(WIDTH_M) + 1;

  booth_state_t        r_state;
  logic [WIDTH_M:0]    r_accA;
  logic [WIDTH_M-1:0]  r_q;
  logic                r_q1;
  logic [WIDTH_M:0]    r_m;
  logic [CW-1:0]       r_count;
  logic [WIDTH_FP-1:0] r_product;
  logic                r_enFp;
  logic                r_ready;

  logic [WIDTH_M:0]    w_nextA;
  logic [WIDTH_M-1:0]  w_nextQ;
  logic                w_nextQ1;

  booth_step #(
    .WIDTH_M (WIDTH_M)
  ) u_step (
    .i_a  (r_accA),
    .i_q  (r_q),
    .i_q1 (r_q1),
    .i_m  (r_m),
    .o_a  (w_nextA),
    .o_q  (w_nextQ),
    .o_q1 (w_nextQ1)
  );

  // Control FSM and datapath registers; outputs are registered so en_fp is a
  // clean single-cycle strobe and product holds between results.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_accA    <= '0;
      r_q       <= '0;
      r_q1      <= 1'b0;
      r_m       <= '0;
      r_count   <= '0;
      r_product <= '0;
      r_enFp    <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_enFp <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_m     <= {multiplicand[WIDTH_M-1], multiplicand};
            r_q     <= multiplier;
            r_accA  <= '0;
            r_q1    <= 1'b0;
            r_count <= CW'(WIDTH_M);
            r_ready <= 1'b0;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_accA  <= w_nextA;
          r_q     <= w_nextQ;
          r_q1    <= w_nextQ1;
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_product <= WIDTH_FP'({r_accA[WIDTH_M-1:0], r_q});
          r_enFp    <= 1'b1;
          r_ready   <= 1'b1;
          r_state   <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready   = r_ready;
  assign product = r_product;
  assign en_fp   = r_enFp;

endmodule

// File: tb/tb_booth_mult_core.sv
// Directed testbench for booth_mult_core with hand-computed expected products.
module tb_booth_mult_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic        ready;
  logic [31:0] product;
  logic        en_fp;

  int checks   = 0;
  int failures = 0;

  logic [31:0] fpCapture;

  logic [15:0] cornerM   [3] = '{16'h8000, 16'h8000, 16'h0000};
  logic [15:0] cornerQ   [3] = '{16'h8000, 16'h7FFF, 16'hFFFF};
  logic [31:0] cornerExp [3] = '{32'h40000000, 32'hC0008000, 32'h00000000};

  booth_mult_core dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .ready        (ready),
    .product      (product),
    .en_fp        (en_fp)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Stand-in for the downstream final_product register capturing on en_fp
  always @(posedge clk) begin
    if (reset) fpCapture <= '0;
    else if (en_fp) fpCapture <= product;
  end

  // Present operands and hold start across exactly one rising edge
  task automatic launch(input logic [15:0] m, input logic [15:0] q);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Watch a fixed window of cycles, recording en_fp pulses and ready rising
  task automatic waitResult(output int pulseCycle, output int readyCycle, output int pulses);
    pulseCycle = -1;
    readyCycle = -1;
    pulses     = 0;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (en_fp) begin
        pulses++;
        if (pulseCycle < 0) pulseCycle = c;
      end
      if (ready && readyCycle < 0) readyCycle = c;
    end
  endtask

  task automatic test_reset();
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    reset        = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++; if (ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b want=1", ready); end
    checks++; if (en_fp !== 1'b0) begin failures++; $display("[TB] FAIL reset_en_fp got=%b want=0", en_fp); end
    checks++; if (product !== 32'h0) begin failures++; $display("[TB] FAIL reset_product got=%h want=00000000", product); end
  endtask

  task automatic test_basic();
    int pc, rc, np;
    launch(16'd3, 16'd5);
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin failures++; $display("[TB] FAIL basic_ready_drop got=%b want=0", ready); end
    waitResult(pc, rc, np);
    checks++; if (pc != 17) begin failures++; $display("[TB] FAIL basic_latency got=%0d want=17", pc); end
    checks++; if (np != 1) begin failures++; $display("[TB] FAIL basic_pulses got=%0d want=1", np); end
    checks++; if (rc != 17) begin failures++; $display("[TB] FAIL basic_ready_return got=%0d want=17", rc); end
    checks++; if (product !== 32'h0000000F) begin failures++; $display("[TB] FAIL basic_product got=%h want=0000000f", product); end
    checks++; if (fpCapture !== 32'h0000000F) begin failures++; $display("[TB] FAIL basic_capture got=%h want=0000000f", fpCapture); end
  endtask

  task automatic test_signed();
    int pc, rc, np;
    launch(16'hFFF9, 16'd6);
    waitResult(pc, rc, np);
    checks++; if (np != 1) begin failures++; $display("[TB] FAIL signed_a_pulses got=%0d want=1", np); end
    checks++; if (product !== 32'hFFFFFFD6) begin failures++; $display("[TB] FAIL signed_a_product got=%h want=ffffffd6", product); end
    launch(16'd6, 16'hFFF9);
    waitResult(pc, rc, np);
    checks++; if (np != 1) begin failures++; $display("[TB] FAIL signed_b_pulses got=%0d want=1", np); end
    checks++; if (product !== 32'hFFFFFFD6) begin failures++; $display("[TB] FAIL signed_b_product got=%h want=ffffffd6", product); end
  endtask

  task automatic test_corners();
    int pc, rc, np;
    for (int i = 0; i < 3; i++) begin
      launch(cornerM[i], cornerQ[i]);
      waitResult(pc, rc, np);
      checks++; if (pc != 17) begin failures++; $display("[TB] FAIL corner%0d_latency got=%0d want=17", i, pc); end
      checks++; if (product !== cornerExp[i]) begin failures++; $display("[TB] FAIL corner%0d_product got=%h want=%h", i, product, cornerExp[i]); end
    end
  endtask

  task automatic test_ignored_start();
    int pc = -1;
    int rc = -1;
    int np = 0;
    launch(16'd100, 16'd200);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (c == 4 || c == 15) begin
        start        = 1'b1;
        multiplicand = 16'd1;
        multiplier   = 16'd1;
      end
      if (c == 5 || c == 17) start = 1'b0;
      @(negedge clk);
      if (en_fp) begin
        np++;
        if (pc < 0) pc = c;
      end
      if (ready && rc < 0) rc = c;
    end
    checks++; if (np != 1) begin failures++; $display("[TB] FAIL ignored_pulses got=%0d want=1", np); end
    checks++; if (pc != 17) begin failures++; $display("[TB] FAIL ignored_latency got=%0d want=17", pc); end
    checks++; if (rc != 17) begin failures++; $display("[TB] FAIL ignored_ready_return got=%0d want=17", rc); end
    checks++; if (product !== 32'h00004E20) begin failures++; $display("[TB] FAIL ignored_product got=%h want=00004e20", product); end
  endtask

  task automatic test_reset_abort();
    int pc, rc, np;
    int early = 0;
    launch(16'd1234, 16'hFFFF);
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (en_fp) early++;
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++; if (ready !== 1'b1) begin failures++; $display("[TB] FAIL abort_ready got=%b want=1", ready); end
    checks++; if (en_fp !== 1'b0) begin failures++; $display("[TB] FAIL abort_en_fp got=%b want=0", en_fp); end
    checks++; if (product !== 32'h0) begin failures++; $display("[TB] FAIL abort_product got=%h want=00000000", product); end
    waitResult(pc, rc, np);
    checks++; if (np + early != 0) begin failures++; $display("[TB] FAIL abort_no_pulse got=%0d want=0", np + early); end
    launch(16'd2, 16'd2);
    waitResult(pc, rc, np);
    checks++; if (np != 1) begin failures++; $display("[TB] FAIL abort_next_pulses got=%0d want=1", np); end
    checks++; if (product !== 32'h00000004) begin failures++; $display("[TB] FAIL abort_next_product got=%h want=00000004", product); end
  endtask

  task automatic test_back_to_back();
    int p1 = -1;
    int p2 = -1;
    int np = 0;
    logic [31:0] v1 = '0;
    logic [31:0] v2 = '0;
    logic [31:0] cap1 = '0;
    logic [31:0] cap2 = '0;
    multiplicand = 16'd9;
    multiplier   = 16'd9;
    start        = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        multiplicand = 16'd10;
        multiplier   = 16'd10;
      end
      if (c == 18) start = 1'b0;
      @(negedge clk);
      if (en_fp) begin
        np++;
        if (p1 < 0) begin p1 = c; v1 = product; end
        else if (p2 < 0) begin p2 = c; v2 = product; end
      end
      if (p1 >= 0 && c == p1 + 1) cap1 = fpCapture;
      if (p2 >= 0 && c == p2 + 1) cap2 = fpCapture;
    end
    start = 1'b0;
    checks++; if (np != 2) begin failures++; $display("[TB] FAIL b2b_pulses got=%0d want=2", np); end
    checks++; if (p2 - p1 != 18) begin failures++; $display("[TB] FAIL b2b_spacing got=%0d want=18", p2 - p1); end
    checks++; if (v1 !== 32'h00000051) begin failures++; $display("[TB] FAIL b2b_first got=%h want=00000051", v1); end
    checks++; if (v2 !== 32'h00000064) begin failures++; $display("[TB] FAIL b2b_second got=%h want=00000064", v2); end
    checks++; if (cap1 !== 32'h00000051) begin failures++; $display("[TB] FAIL b2b_capture1 got=%h want=00000051", cap1); end
    checks++; if (cap2 !== 32'h00000064) begin failures++; $display("[TB] FAIL b2b_capture2 got=%h want=00000064", cap2); end
  endtask

  // Scenario sequence followed by the summary line
  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_corners();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
